// File: rtl/fo_issuer.sv
// Major-clock-domain issuer of FO bitmaps: takes duplicate-group bitmaps over valid/ready,
// holds each one in FO_mj_reg, toggles mj_level per issue and waits for the minor-domain drain.
module fo_issuer #(
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4,
  parameter int GUARD_CYC        = 8
) (
  input  logic                        clk_mj,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic [ELEMENT_NUM-1:0]      fo_in,
  input  logic                        fo_valid,
  output logic                        fo_ready,
  output logic [ELEMENT_NUM-1:0]      FO_mj_reg,
  output logic                        mj_level,
  input  logic                        TR_empty,
  output logic [LOG2_ELEMENT_NUM:0]   issued_cnt,
  output logic                        sort_done,
  output logic                        overflow_err
);

  localparam int CW = LOG2_ELEMENT_NUM + 1;
  localparam int SW = LOG2_ELEMENT_NUM + 2;
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic           te_meta_reg, te_sync_reg;
  logic [GW-1:0]  guard_reg;
  logic [SW-1:0]  pop_cnt;
  logic [SW-1:0]  cnt_sum;
  logic           issue;
  logic           cnt_full;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < ELEMENT_NUM; i++) begin
      pop_cnt = pop_cnt + SW'(fo_in[i]);
    end
  end

  assign cnt_sum  = SW'(issued_cnt) + pop_cnt;
  // A zero bitmap is accepted but never issued.
  assign issue    = (state_reg == S_READY) && fo_valid && (fo_in != '0);
  assign cnt_full = (issued_cnt == CW'(ELEMENT_NUM));

  // TR_empty comes from the minor domain; only the second flop is ever observed.
  always_ff @(posedge clk_mj or negedge rst_n) begin
    if (!rst_n) begin
      te_meta_reg <= 1'b1;
      te_sync_reg <= 1'b1;
    end else begin
      te_meta_reg <= TR_empty;
      te_sync_reg <= te_meta_reg;
    end
  end

  always_ff @(posedge clk_mj or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (mode) state_next = S_READY;
      S_READY: if (issue) state_next = S_GUARD;
      // te_sync may still show the previous level here, so it is ignored.
      S_GUARD: if (guard_reg == '0) state_next = S_WAIT;
      S_WAIT:  if (te_sync_reg) state_next = cnt_full ? S_DONE : S_READY;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (!mode) begin
      state_next = S_IDLE;
    end
  end

  always_comb begin
    fo_ready  = (state_reg == S_READY);
    sort_done = (state_reg == S_DONE);
  end

  always_ff @(posedge clk_mj or negedge rst_n) begin
    if (!rst_n) begin
      guard_reg <= '0;
    end else if (issue) begin
      guard_reg <= GW'(GUARD_CYC - 1);
    end else if ((state_reg == S_GUARD) && (guard_reg != '0)) begin
      guard_reg <= guard_reg - GW'(1);
    end
  end

  // An accept coinciding with mode falling still completes.
  always_ff @(posedge clk_mj or negedge rst_n) begin
    if (!rst_n) begin
      FO_mj_reg <= '0;
      mj_level  <= 1'b0;
    end else if (issue) begin
      FO_mj_reg <= fo_in;
      mj_level  <= ~mj_level;
    end
  end

  always_ff @(posedge clk_mj or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt   <= '0;
      overflow_err <= 1'b0;
    end else if ((state_reg == S_IDLE) && mode) begin
      issued_cnt   <= '0;
      overflow_err <= 1'b0;
    end else if (issue) begin
      if (cnt_sum > SW'(ELEMENT_NUM)) begin
        issued_cnt   <= CW'(ELEMENT_NUM);
        overflow_err <= 1'b1;
      end else begin
        issued_cnt <= cnt_sum[CW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fo_issuer.sv
// Directed and randomized bench for fo_issuer, checked against a transaction-level model
// of issued bitmaps, level, count, overflow and ready timing.
module tb_fo_issuer;

  localparam int EN = 16;
  localparam int LG = 4;
  localparam int GC = 8;

  logic          clk_mj   = 1'b0;
  logic          rst_n    = 1'b0;
  logic          mode     = 1'b0;
  logic [EN-1:0] fo_in    = '0;
  logic          fo_valid = 1'b0;
  logic          TR_empty = 1'b1;
  logic          fo_ready;
  logic [EN-1:0] FO_mj_reg;
  logic          mj_level;
  logic [LG:0]   issued_cnt;
  logic          sort_done;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  logic [EN-1:0] m_fo  = '0;
  logic          m_lvl = 1'b0;
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;

  fo_issuer #(
    .ELEMENT_NUM     (EN),
    .LOG2_ELEMENT_NUM(LG),
    .GUARD_CYC       (GC)
  ) dut (
    .clk_mj      (clk_mj),
    .rst_n       (rst_n),
    .mode        (mode),
    .fo_in       (fo_in),
    .fo_valid    (fo_valid),
    .fo_ready    (fo_ready),
    .FO_mj_reg   (FO_mj_reg),
    .mj_level    (mj_level),
    .TR_empty    (TR_empty),
    .issued_cnt  (issued_cnt),
    .sort_done   (sort_done),
    .overflow_err(overflow_err)
  );

  always #5 clk_mj = ~clk_mj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_mj);
  endtask

  task automatic model_accept(input logic [EN-1:0] bm);
    int sum;
    if (bm != '0) begin
      sum = m_cnt + $countones(bm);
      if (sum > EN) begin
        m_cnt = EN;
        m_ovf = 1'b1;
      end else begin
        m_cnt = sum;
      end
      m_fo  = bm;
      m_lvl = ~m_lvl;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_fo"},  32'(FO_mj_reg),    32'(m_fo));
    chk({tag, "_lvl"}, 32'(mj_level),     32'(m_lvl));
    chk({tag, "_cnt"}, 32'(issued_cnt),   32'(m_cnt));
    chk({tag, "_ovf"}, 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic start();
    mode = 1'b1;
    tick();
    m_cnt = 0;
    m_ovf = 1'b0;
    chk("start_ready", 32'(fo_ready), 32'd1);
    chk("start_cnt", 32'(issued_cnt), 32'd0);
    chk("start_ovf", 32'(overflow_err), 32'd0);
  endtask

  task automatic stop();
    mode = 1'b0;
    tick();
    chk("stop_ready", 32'(fo_ready), 32'd0);
    chk("stop_done", 32'(sort_done), 32'd0);
  endtask

  // TR_empty is held low from the accept and raised after edge r (r=0: never dropped).
  task automatic issue(input logic [EN-1:0] bm, input int r);
    int k;
    int exp_k;
    logic m_done;
    chk("pre_ready", 32'(fo_ready), 32'd1);
    fo_in    = bm;
    fo_valid = 1'b1;
    tick();
    fo_valid = 1'b0;
    model_accept(bm);
    check_model("accept");
    if (bm == '0) begin
      chk("zero_ready", 32'(fo_ready), 32'd1);
      $display("issue bm=%04h zero-discard cnt=%0d", bm, m_cnt);
      return;
    end
    if (r > 0) TR_empty = 1'b0;
    exp_k  = (r == 0) ? GC + 1 : (((r + 3) > (GC + 1)) ? r + 3 : GC + 1);
    m_done = (m_cnt == EN);
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (k == r) TR_empty = 1'b1;
      if (fo_ready || sort_done) break;
    end
    TR_empty = 1'b1;
    chk("ready_latency", 32'(k), 32'(exp_k));
    chk("end_done", 32'(sort_done), 32'(m_done));
    chk("end_ready", 32'(fo_ready), 32'(!m_done));
    $display("issue bm=%04h r=%0d cnt=%0d lvl=%0d cycles=%0d", bm, r, m_cnt, m_lvl, k);
  endtask

  initial begin
    logic [EN-1:0] bm;
    int r;

    // Reset values and idle with mode low
    repeat (3) tick();
    check_model("reset");
    chk("reset_ready", 32'(fo_ready), 32'd0);
    chk("reset_done", 32'(sort_done), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_ready", 32'(fo_ready), 32'd0);
      chk("idle_lvl", 32'(mj_level), 32'd0);
    end

    // Single issue, drain handshake, zero bitmap
    start();
    issue(16'h0005, 0);
    issue(16'h00F0, 20);
    issue(16'h0000, 0);

    // Completion
    stop();
    start();
    issue(16'hFF00, 0);
    issue(16'h00FF, 5);
    chk("compl_cnt", 32'(issued_cnt), 32'd16);
    mode = 1'b0;
    tick();
    chk("compl_abort_done", 32'(sort_done), 32'd0);

    // Overflow, then abort during the guard window
    start();
    issue(16'h0003, 0);
    fo_in    = 16'hFFFF;
    fo_valid = 1'b1;
    tick();
    fo_valid = 1'b0;
    model_accept(16'hFFFF);
    check_model("ovf");
    repeat (3) tick();
    mode = 1'b0;
    tick();
    chk("abort_ready", 32'(fo_ready), 32'd0);
    repeat (12) tick();
    chk("abort_done", 32'(sort_done), 32'd0);
    chk("abort_ready_late", 32'(fo_ready), 32'd0);
    check_model("abort_hold");
    $display("abort during guard lvl=%0d ovf=%0d", mj_level, overflow_err);

    // Accept in the same cycle mode falls
    start();
    mode     = 1'b0;
    fo_in    = 16'h0810;
    fo_valid = 1'b1;
    tick();
    fo_valid = 1'b0;
    model_accept(16'h0810);
    chk("mfall_fo", 32'(FO_mj_reg), 32'(m_fo));
    chk("mfall_lvl", 32'(mj_level), 32'(m_lvl));
    chk("mfall_ready", 32'(fo_ready), 32'd0);
    repeat (12) tick();
    chk("mfall_ready_late", 32'(fo_ready), 32'd0);
    $display("accept with mode fall fo=%04h lvl=%0d", FO_mj_reg, mj_level);

    // Reset asserted mid-guard
    start();
    fo_in    = 16'h0101;
    fo_valid = 1'b1;
    tick();
    fo_valid = 1'b0;
    model_accept(16'h0101);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    m_fo  = '0;
    m_lvl = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    check_model("async_rst");
    chk("async_rst_ready", 32'(fo_ready), 32'd0);
    chk("async_rst_done", 32'(sort_done), 32'd0);
    mode = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_ready", 32'(fo_ready), 32'd0);
      chk("post_rst_lvl", 32'(mj_level), 32'd0);
    end
    $display("async reset mid-guard done");

    // Randomized issues with random drain delays
    start();
    for (int it = 0; it < 40; it++) begin
      if (m_cnt == EN) begin
        stop();
        start();
      end
      bm = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 4) == 0) bm = '0;
      r = int'($urandom_range(0, 14));
      issue(bm, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
